// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream input and packet output bundle for spi_cmd_decoder.
// The master side is the SPI byte front-end; the slave side is the decoder.
// The pkt_count/err_count members exist only when SPI_CMD_DECODER_STATS_EN is defined.
interface spi_cmd_decoder_if #(
  parameter int unsigned VTX_W   = 108,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TRANS_W = 288
);
  logic                 frame_active;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 opcode_valid;
  logic [3:0]           opcode;
  logic                 vert_valid;
  logic [12:0]          vert_base;
  logic [CNT_W-1:0]     vert_count;
  logic                 next_vert_valid;
  logic [VTX_W-1:0]     vert_in;
  logic                 tri_valid;
  logic [12:0]          tri_base;
  logic [CNT_W-1:0]     tri_count;
  logic                 next_tri_valid;
  logic [3*CNT_W-1:0]   tri_in;
  logic                 inst_valid;
  logic [CNT_W-1:0]     vert_id;
  logic [CNT_W-1:0]     tri_id;
  logic [CNT_W-1:0]     inst_id;
  logic [TRANS_W-1:0]   transform;
  logic                 err_valid;
  logic [2:0]           err_code;
`ifdef SPI_CMD_DECODER_STATS_EN
  logic [15:0]          pkt_count;
  logic [15:0]          err_count;

  modport master (
    output frame_active, byte_valid, byte_data,
    input  opcode_valid, opcode, vert_valid, vert_base, vert_count,
           next_vert_valid, vert_in, tri_valid, tri_base, tri_count,
           next_tri_valid, tri_in, inst_valid, vert_id, tri_id, inst_id,
           transform, err_valid, err_code, pkt_count, err_count
  );

  modport slave (
    input  frame_active, byte_valid, byte_data,
    output opcode_valid, opcode, vert_valid, vert_base, vert_count,
           next_vert_valid, vert_in, tri_valid, tri_base, tri_count,
           next_tri_valid, tri_in, inst_valid, vert_id, tri_id, inst_id,
           transform, err_valid, err_code, pkt_count, err_count
  );
`else
  modport master (
    output frame_active, byte_valid, byte_data,
    input  opcode_valid, opcode, vert_valid, vert_base, vert_count,
           next_vert_valid, vert_in, tri_valid, tri_base, tri_count,
           next_tri_valid, tri_in, inst_valid, vert_id, tri_id, inst_id,
           transform, err_valid, err_code
  );

  modport slave (
    input  frame_active, byte_valid, byte_data,
    output opcode_valid, opcode, vert_valid, vert_base, vert_count,
           next_vert_valid, vert_in, tri_valid, tri_base, tri_count,
           next_tri_valid, tri_in, inst_valid, vert_id, tri_id, inst_id,
           transform, err_valid, err_code
  );
`endif
endinterface

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns framed SPI bytes into geometry-memory packets
// (opcode, vertex/triangle headers and words, instance records) and flags
// bad opcodes, truncated frames and buffer overflows on err_valid/err_code.
// Optional packet/error counters: define SPI_CMD_DECODER_STATS_EN.
module spi_cmd_decoder #(
  parameter int unsigned MAX_VERT = 5000,
  parameter int unsigned MAX_TRI  = 5000,
  parameter int unsigned VTX_W    = 108,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TRANS_W  = 288
) (
  input  logic             clk,
  input  logic             rst,
  spi_cmd_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_OPC, S_HDR, S_VDATA, S_TDATA, S_XFORM, S_DISCARD
  } state_t;

  localparam logic [3:0] OP_WIPE   = 4'd0;
  localparam logic [3:0] OP_VERT   = 4'd1;
  localparam logic [3:0] OP_TRI    = 4'd2;
  localparam logic [3:0] OP_CREATE = 4'd3;
  localparam logic [3:0] OP_UPDATE = 4'd4;

  localparam logic [2:0] ERR_OPC   = 3'd1;
  localparam logic [2:0] ERR_TRUNC = 3'd2;
  localparam logic [2:0] ERR_OVF   = 3'd3;

  localparam logic [5:0] VTX_LAST  = 6'd13;  // 14-byte vertex
  localparam logic [5:0] TRI_LAST  = 6'd2;   // 3-byte triangle
  localparam logic [5:0] XF_LAST   = 6'd35;  // 36-byte transform

  state_t               r_state, w_state_nxt;
  logic [5:0]           r_cnt, w_cnt_nxt;
  logic [7:0]           r_words, w_words_nxt;
  logic [3:0]           r_op, w_op_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic [TRANS_W-1:0]   r_shift;
  logic [TRANS_W-1:0]   w_shift_nxt;
  logic                 w_byte;
  logic [3:0]           w_opc;
  logic [5:0]           w_hdr_last;
  logic [12:0]          w_base;
  logic [7:0]           w_count;
  logic [13:0]          w_sum;
  logic                 w_over;

  logic w_ld_opc, w_ld_vhdr, w_ld_vdata, w_ld_thdr, w_ld_tdata;
  logic w_ld_cid, w_ld_uid, w_ld_inst;
  logic w_err, w_pkt_done, w_wipe;
  logic [2:0] w_err_code;

  logic                 r_opcode_valid;
  logic [3:0]           r_opcode;
  logic                 r_vert_valid;
  logic [12:0]          r_vert_base;
  logic [CNT_W-1:0]     r_vert_count;
  logic                 r_next_vert_valid;
  logic [VTX_W-1:0]     r_vert_in;
  logic                 r_tri_valid;
  logic [12:0]          r_tri_base;
  logic [CNT_W-1:0]     r_tri_count;
  logic                 r_next_tri_valid;
  logic [3*CNT_W-1:0]   r_tri_in;
  logic                 r_inst_valid;
  logic [CNT_W-1:0]     r_vert_id, r_tri_id, r_inst_id;
  logic [CNT_W-1:0]     r_vid_h, r_tid_h, r_iid_h;
  logic                 r_create;
  logic [TRANS_W-1:0]   r_transform;
  logic                 r_err_valid;
  logic [2:0]           r_err_code;

  // Big-endian assembly: every accepted byte shifts in at the LSB end, so the
  // most recent N bytes of any field always sit in the low 8*N bits.
  assign w_byte      = bus.frame_active & bus.byte_valid;
  assign w_shift_nxt = {r_shift[TRANS_W-9:0], bus.byte_data};
  assign w_opc       = bus.byte_data[3:0];
  assign w_base      = w_shift_nxt[20:8];
  assign w_count     = w_shift_nxt[7:0];
  assign w_sum       = {1'b0, w_base} + {6'b0, w_count};
  assign w_over      = (r_op == OP_VERT) ? (w_sum > 14'(MAX_VERT))
                                         : (w_sum > 14'(MAX_TRI));

  // Header length per opcode, as the index of its final byte.
  always_comb begin
    w_hdr_last = 6'd0;
    case (r_op)
      OP_VERT, OP_TRI: w_hdr_last = 6'd2;
      OP_CREATE:       w_hdr_last = 6'd1;
      default:         w_hdr_last = 6'd0;
    endcase
  end

  // State register and byte/word counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_OPC;
      r_cnt   <= '0;
      r_words <= '0;
      r_op    <= '0;
      r_ovf   <= 1'b0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_words <= w_words_nxt;
      r_op    <= w_op_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_byte) r_shift <= w_shift_nxt;
    end
  end

  // Next-state decode and per-cycle load strobes for the output registers.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_words_nxt = r_words;
    w_op_nxt    = r_op;
    w_ovf_nxt   = r_ovf;
    w_ld_opc    = 1'b0;
    w_ld_vhdr   = 1'b0;
    w_ld_vdata  = 1'b0;
    w_ld_thdr   = 1'b0;
    w_ld_tdata  = 1'b0;
    w_ld_cid    = 1'b0;
    w_ld_uid    = 1'b0;
    w_ld_inst   = 1'b0;
    w_err       = 1'b0;
    w_err_code  = '0;
    w_pkt_done  = 1'b0;
    w_wipe      = 1'b0;
    if (!bus.frame_active) begin
      // Frame end: a packet still in progress is truncated; any byte this cycle is dropped.
      w_state_nxt = S_OPC;
      w_cnt_nxt   = '0;
      if (r_state != S_OPC && r_state != S_DISCARD) begin
        w_err      = 1'b1;
        w_err_code = ERR_TRUNC;
      end
    end else if (bus.byte_valid) begin
      case (r_state)
        S_OPC: begin
          w_cnt_nxt = '0;
          if (w_opc <= OP_UPDATE) begin
            w_ld_opc = 1'b1;
            w_op_nxt = w_opc;
            if (w_opc == OP_WIPE) begin
              w_wipe     = 1'b1;
              w_pkt_done = 1'b1;
            end else begin
              w_state_nxt = S_HDR;
            end
          end else begin
            w_err       = 1'b1;
            w_err_code  = ERR_OPC;
            w_state_nxt = S_DISCARD;
          end
        end
        S_HDR: begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == w_hdr_last) begin
            w_cnt_nxt = '0;
            if (r_op == OP_VERT || r_op == OP_TRI) begin
              // Overflowed buffers still consume their data bytes, silently.
              w_ovf_nxt   = w_over;
              w_words_nxt = w_count;
              if (w_over) begin
                w_err      = 1'b1;
                w_err_code = ERR_OVF;
              end else if (r_op == OP_VERT) begin
                w_ld_vhdr = 1'b1;
              end else begin
                w_ld_thdr = 1'b1;
              end
              if (w_count == 8'd0) begin
                w_state_nxt = S_OPC;
                w_pkt_done  = !w_over;
              end else begin
                w_state_nxt = (r_op == OP_VERT) ? S_VDATA : S_TDATA;
              end
            end else begin
              w_ld_cid    = (r_op == OP_CREATE);
              w_ld_uid    = (r_op == OP_UPDATE);
              w_state_nxt = S_XFORM;
            end
          end
        end
        S_VDATA: begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == VTX_LAST) begin
            w_cnt_nxt   = '0;
            w_ld_vdata  = !r_ovf;
            w_words_nxt = r_words - 8'd1;
            if (r_words == 8'd1) begin
              w_state_nxt = S_OPC;
              w_pkt_done  = !r_ovf;
            end
          end
        end
        S_TDATA: begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == TRI_LAST) begin
            w_cnt_nxt   = '0;
            w_ld_tdata  = !r_ovf;
            w_words_nxt = r_words - 8'd1;
            if (r_words == 8'd1) begin
              w_state_nxt = S_OPC;
              w_pkt_done  = !r_ovf;
            end
          end
        end
        S_XFORM: begin
          w_cnt_nxt = r_cnt + 6'd1;
          if (r_cnt == XF_LAST) begin
            w_cnt_nxt   = '0;
            w_ld_inst   = 1'b1;
            w_pkt_done  = 1'b1;
            w_state_nxt = S_OPC;
          end
        end
        default: ;
      endcase
    end
  end

  // Output pulses and held data fields, registered one cycle after the completing byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode_valid    <= 1'b0;
      r_opcode          <= '0;
      r_vert_valid      <= 1'b0;
      r_vert_base       <= '0;
      r_vert_count      <= '0;
      r_next_vert_valid <= 1'b0;
      r_vert_in         <= '0;
      r_tri_valid       <= 1'b0;
      r_tri_base        <= '0;
      r_tri_count       <= '0;
      r_next_tri_valid  <= 1'b0;
      r_tri_in          <= '0;
      r_inst_valid      <= 1'b0;
      r_vert_id         <= '0;
      r_tri_id          <= '0;
      r_inst_id         <= '0;
      r_vid_h           <= '0;
      r_tid_h           <= '0;
      r_iid_h           <= '0;
      r_create          <= 1'b0;
      r_transform       <= '0;
      r_err_valid       <= 1'b0;
      r_err_code        <= '0;
    end else begin
      r_opcode_valid    <= w_ld_opc;
      r_vert_valid      <= w_ld_vhdr;
      r_next_vert_valid <= w_ld_vdata;
      r_tri_valid       <= w_ld_thdr;
      r_next_tri_valid  <= w_ld_tdata;
      r_inst_valid      <= w_ld_inst;
      r_err_valid       <= w_err;
      if (w_ld_opc) r_opcode <= w_opc;
      if (w_err)    r_err_code <= w_err_code;
      if (w_ld_vhdr) begin
        r_vert_base  <= w_base;
        r_vert_count <= w_count[CNT_W-1:0];
      end
      if (w_ld_thdr) begin
        r_tri_base  <= w_base;
        r_tri_count <= w_count[CNT_W-1:0];
      end
      if (w_ld_vdata) r_vert_in <= w_shift_nxt[VTX_W-1:0];
      if (w_ld_tdata) r_tri_in  <= w_shift_nxt[3*CNT_W-1:0];
      // Ids are staged at header time and only published with inst_valid.
      if (w_ld_cid) begin
        r_vid_h  <= w_shift_nxt[15:8];
        r_tid_h  <= w_shift_nxt[7:0];
        r_create <= 1'b1;
      end
      if (w_ld_uid) begin
        r_iid_h  <= w_shift_nxt[7:0];
        r_create <= 1'b0;
      end
      if (w_ld_inst) begin
        r_transform <= w_shift_nxt;
        if (r_create) begin
          r_vert_id <= r_vid_h;
          r_tri_id  <= r_tid_h;
        end else begin
          r_inst_id <= r_iid_h;
        end
      end
    end
  end

  assign bus.opcode_valid    = r_opcode_valid;
  assign bus.opcode          = r_opcode;
  assign bus.vert_valid      = r_vert_valid;
  assign bus.vert_base       = r_vert_base;
  assign bus.vert_count      = r_vert_count;
  assign bus.next_vert_valid = r_next_vert_valid;
  assign bus.vert_in         = r_vert_in;
  assign bus.tri_valid       = r_tri_valid;
  assign bus.tri_base        = r_tri_base;
  assign bus.tri_count       = r_tri_count;
  assign bus.next_tri_valid  = r_next_tri_valid;
  assign bus.tri_in          = r_tri_in;
  assign bus.inst_valid      = r_inst_valid;
  assign bus.vert_id         = r_vert_id;
  assign bus.tri_id          = r_tri_id;
  assign bus.inst_id         = r_inst_id;
  assign bus.transform       = r_transform;
  assign bus.err_valid       = r_err_valid;
  assign bus.err_code        = r_err_code;

`ifdef SPI_CMD_DECODER_STATS_EN
  logic [15:0] r_pkt_count, r_err_count;

  // Saturating packet/error counters; a WIPE clears both, taking priority
  // over counting the WIPE itself as a completed packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else if (w_wipe) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_pkt_done && r_pkt_count != '1) r_pkt_count <= r_pkt_count + 16'd1;
      if (w_err && r_err_count != '1)      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.pkt_count = r_pkt_count;
  assign bus.err_count = r_err_count;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: byte sequences with hand-computed
// expected pulse counts and field values.
module tb_spi_cmd_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_cmd_decoder_if bus ();

  spi_cmd_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Pulse tallies: 0 opcode, 1 vert hdr, 2 vert word, 3 tri hdr, 4 tri word, 5 inst, 6 err.
  int n_p [7];
  int s_p [7];
  int n_excl = 0;
  logic [107:0] vw [4];
  logic [6:0]   mon_p;
  logic [287:0] exp_x;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon_p = {bus.err_valid, bus.inst_valid, bus.next_tri_valid, bus.tri_valid,
               bus.next_vert_valid, bus.vert_valid, bus.opcode_valid};
      if ($countones(mon_p) > 1) n_excl++;
      if (bus.next_vert_valid) vw[n_p[2] % 4] = bus.vert_in;
      for (int i = 0; i < 7; i++) if (mon_p[i]) n_p[i]++;
    end
  end

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic snap();
    for (int i = 0; i < 7; i++) s_p[i] = n_p[i];
  endtask

  function automatic int dlt(input int i);
    return n_p[i] - s_p[i];
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic frame(input logic v);
    @(negedge clk);
    bus.byte_valid   = 1'b0;
    bus.frame_active = v;
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_active = 1'b0;
    bus.byte_valid   = 1'b0;
    bus.byte_data    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_opcode_valid", bus.opcode_valid, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_transform", bus.transform, 0);
    rst = 1'b0;

    // VERT base 0x010, two vertices
    frame(1'b1);
    snap();
    send(8'h01); send(8'h00); send(8'h10); send(8'h02);
    for (int i = 0; i < 14; i++) send(8'hA1 + 8'(i));
    for (int i = 0; i < 14; i++) send(8'h01 + 8'(i));
    idle(3);
    check("vert_opc_pulses", dlt(0), 1);
    check("vert_opcode", bus.opcode, 1);
    check("vert_hdr_pulses", dlt(1), 1);
    check("vert_base", bus.vert_base, 13'h010);
    check("vert_count", bus.vert_count, 2);
    check("vert_word_pulses", dlt(2), 2);
    check("vert_word0", vw[0], 108'h1A2A3A4A5A6A7A8A9AAABACADAE);
    check("vert_word1", vw[1], 108'h102030405060708090A0B0C0D0E);
    check("vert_err_pulses", dlt(6), 0);

    // TRI overflow: 4998 + 5 > 5000, then WIPE
    snap();
    send(8'h02); send(8'h13); send(8'h86); send(8'h05);
    for (int i = 0; i < 15; i++) send(8'h60 + 8'(i));
    send(8'h00);
    idle(3);
    check("ovf_err_pulses", dlt(6), 1);
    check("ovf_err_code", bus.err_code, 3);
    check("ovf_tri_hdr", dlt(3), 0);
    check("ovf_tri_words", dlt(4), 0);
    check("ovf_opc_pulses", dlt(0), 2);
    check("ovf_then_wipe_opcode", bus.opcode, 0);

    // TRI at the limit: 4995 + 5 == 5000 is accepted
    snap();
    send(8'h02); send(8'h13); send(8'h83); send(8'h05);
    for (int i = 0; i < 15; i++) send(8'h30 + 8'(i));
    idle(3);
    check("lim_tri_hdr", dlt(3), 1);
    check("lim_tri_base", bus.tri_base, 13'h1383);
    check("lim_tri_count", bus.tri_count, 5);
    check("lim_tri_words", dlt(4), 5);
    check("lim_last_tri", bus.tri_in, 24'h3C3D3E);
    check("lim_err_pulses", dlt(6), 0);

    // CREATE_INST vert 7, tri 9
    snap();
    exp_x = '0;
    send(8'h03); send(8'h07); send(8'h09);
    for (int i = 0; i < 36; i++) begin
      exp_x = {exp_x[279:0], 8'h40 + 8'(i)};
      send(8'h40 + 8'(i));
    end
    idle(3);
    check("create_pulses", dlt(5), 1);
    check("create_vert_id", bus.vert_id, 7);
    check("create_tri_id", bus.tri_id, 9);
    check("create_transform", bus.transform, exp_x);

    // UPDATE_INST with a set high nibble on the opcode byte
    snap();
    exp_x = '0;
    send(8'h14); send(8'h22);
    for (int i = 0; i < 36; i++) begin
      exp_x = {exp_x[279:0], 8'hC0 + 8'(i)};
      send(8'hC0 + 8'(i));
    end
    idle(3);
    check("update_pulses", dlt(5), 1);
    check("update_opcode", bus.opcode, 4);
    check("update_inst_id", bus.inst_id, 8'h22);
    check("update_keeps_vert_id", bus.vert_id, 7);
    check("update_transform", bus.transform, exp_x);

    // Truncated TRI: one full triangle then frame drop mid-second
    snap();
    send(8'h02); send(8'h00); send(8'h00); send(8'h04);
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
    frame(1'b0);
    idle(3);
    check("trunc_tri_words", dlt(4), 1);
    check("trunc_tri_in", bus.tri_in, 24'h505152);
    check("trunc_err_pulses", dlt(6), 1);
    check("trunc_err_code", bus.err_code, 2);
    frame(1'b1);
    snap();
    send(8'h00);
    idle(3);
    check("after_trunc_opc", dlt(0), 1);
    check("after_trunc_err", dlt(6), 0);

    // Bad opcode, trailing bytes discarded, no error at frame end
    snap();
    send(8'h09); send(8'hAA); send(8'hBB);
    frame(1'b0);
    idle(3);
    check("badop_err_pulses", dlt(6), 1);
    check("badop_err_code", bus.err_code, 1);
    check("badop_other_pulses", dlt(0) + dlt(1) + dlt(2) + dlt(3) + dlt(4) + dlt(5), 0);

    // Byte while frame is low is ignored
    snap();
    send(8'h01);
    idle(3);
    check("nocs_opc_pulses", dlt(0), 0);
    check("nocs_err_pulses", dlt(6), 0);

    // TRI count 0 then WIPE in one frame
    frame(1'b1);
    snap();
    send(8'h02); send(8'h00); send(8'h20); send(8'h00);
    send(8'h00);
    idle(3);
    check("tri0_hdr", dlt(3), 1);
    check("tri0_base", bus.tri_base, 13'h020);
    check("tri0_count", bus.tri_count, 0);
    check("tri0_words", dlt(4), 0);
    check("tri0_opc_pulses", dlt(0), 2);
    check("tri0_wipe_opcode", bus.opcode, 0);
`ifdef SPI_CMD_DECODER_STATS_EN
    check("wipe_pkt_count", bus.pkt_count, 0);
    check("wipe_err_count", bus.err_count, 0);
`endif

    // Reset mid-packet, then a fresh VERT with count 0
    snap();
    send(8'h01); send(8'h00);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    check("midrst_opcode", bus.opcode, 0);
    check("midrst_vert_base", bus.vert_base, 0);
    rst = 1'b0;
    snap();
    send(8'h01); send(8'h00); send(8'h05); send(8'h00);
    idle(3);
    check("postrst_vert_hdr", dlt(1), 1);
    check("postrst_vert_base", bus.vert_base, 13'h005);
    check("postrst_err", dlt(6), 0);
`ifdef SPI_CMD_DECODER_STATS_EN
    check("postrst_pkt_count", bus.pkt_count, 1);
`endif

    check("pulse_exclusive", n_excl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
